quant_table_seq: RTL and testbench



---
 rtl/quant_pkg.sv | 61 ++++++
 rtl/quant_table_seq_if.sv | 31 +++
 rtl/quant_tbl_store.sv | 34 +++
 rtl/quant_table_seq.sv | 94 +++++++++
 tb/tb_quant_table_seq.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quant_pkg.sv
// Shared sizes, types and reset-default reciprocal tables for the quantisation table sequencer.
package quant_pkg;

  localparam int unsigned COEF_W  = 7;
  localparam int unsigned COLS    = 8;
  localparam int unsigned ROWS    = 8;
  localparam int unsigned NUM_TBL = 3;
  localparam int unsigned ZZ_ROWS = 2;
  localparam int unsigned TID_W   = 2;
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned ROW_BITS = COLS * COEF_W;

  localparam int unsigned TBL_Y  = 0;
  localparam int unsigned TBL_CB = 1;
  localparam int unsigned TBL_CR = 2;

  typedef logic [COEF_W-1:0]   coef_t;
  typedef logic [ROW_BITS-1:0] row_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam coef_t DEFAULT_LUMA [ROWS][COLS] = '{
    '{7'd64, 7'd86, 7'd73, 7'd73, 7'd57, 7'd43, 7'd21, 7'd14},
    '{7'd93, 7'd93, 7'd79, 7'd59, 7'd44, 7'd20, 7'd15, 7'd19},
    '{7'd79, 7'd85, 7'd64, 7'd43, 7'd28, 7'd18, 7'd16, 7'd20},
    '{7'd79, 7'd68, 7'd55, 7'd44, 7'd21, 7'd12, 7'd14, 7'd18},
    '{7'd62, 7'd55, 7'd37, 7'd23, 7'd17, 7'd10, 7'd11, 7'd14},
    '{7'd47, 7'd40, 7'd26, 7'd20, 7'd15, 7'd11, 7'd10, 7'd12},
    '{7'd21, 7'd16, 7'd13, 7'd11, 7'd10, 7'd9,  7'd9,  7'd10},
    '{7'd14, 7'd12, 7'd11, 7'd11, 7'd9,  7'd10, 7'd10, 7'd10}
  };

  localparam coef_t DEFAULT_CHROMA [ROWS][COLS] = '{
    '{7'd60, 7'd57, 7'd43, 7'd22, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd57, 7'd49, 7'd39, 7'd15, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd43, 7'd39, 7'd19, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11},
    '{7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11, 7'd11}
  };

  // Packs one default row, col0 in the LSBs.
  function automatic row_t default_row(input logic luma, input int r);
    row_t res;
    res = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      res[c*COEF_W +: COEF_W] = luma ? DEFAULT_LUMA[ROW_W'(r)][COL_W'(c)]
                                     : DEFAULT_CHROMA[ROW_W'(r)][COL_W'(c)];
    end
    return res;
  endfunction

  // True when a table id addresses a real table.
  function automatic logic tbl_ok(input logic [TID_W-1:0] t);
    return 32'(t) < NUM_TBL;
  endfunction

endpackage

// File: rtl/quant_table_seq_if.sv
// Config, block-control and row-output signals between the block controller, the sequencer and the quantiser.
interface quant_table_seq_if;
  import quant_pkg::*;

  logic             cfg_we;
  logic [TID_W-1:0] cfg_tbl;
  logic [ROW_W-1:0] cfg_row;
  row_t             cfg_data;
  logic             cfg_busy;
  logic             blk_start;
  logic [TID_W-1:0] blk_tbl;
  logic             blk_rdy;
  logic             blk_abort;
  logic             out_valid;
  logic             out_ready;
  row_t             out_params;
  logic [ROW_W-1:0] out_row;
  logic             out_last;
  logic             zz_en;

  modport master (
    output cfg_we, cfg_tbl, cfg_row, cfg_data, blk_start, blk_tbl, blk_abort, out_ready,
    input  cfg_busy, blk_rdy, out_valid, out_params, out_row, out_last, zz_en
  );

  modport slave (
    input  cfg_we, cfg_tbl, cfg_row, cfg_data, blk_start, blk_tbl, blk_abort, out_ready,
    output cfg_busy, blk_rdy, out_valid, out_params, out_row, out_last, zz_en
  );

endinterface

// File: rtl/quant_tbl_store.sv
// Register array holding all reciprocal tables: one write port, one combinational read port.
module quant_tbl_store
  import quant_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [TID_W-1:0] wr_tbl,
  input  logic [ROW_W-1:0] wr_row,
  input  row_t             wr_data,
  input  logic [TID_W-1:0] rd_tbl,
  input  logic [ROW_W-1:0] rd_row,
  output row_t             rd_data
);

  row_t mem [NUM_TBL][ROWS];

  // Reset reloads luma into table 0 and chroma everywhere else; otherwise take qualified writes.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int t = 0; t < int'(NUM_TBL); t++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          mem[TID_W'(t)][ROW_W'(r)] <= default_row(t == 0, r);
        end
      end
    end else if (wr_en) begin
      mem[wr_tbl][wr_row] <= wr_data;
    end
  end

  // Out-of-range table ids read as all-zero coefficients.
  assign rd_data = tbl_ok(rd_tbl) ? mem[rd_tbl][rd_row] : '0;

endmodule

// File: rtl/quant_table_seq.sv
// Sequences one block's quantisation table row by row to the quantiser under valid/ready.
module quant_table_seq
  import quant_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  quant_table_seq_if.slave bus
);

  state_t           state_q;
  logic [TID_W-1:0] act_tbl_q;
  logic             out_valid_q;
  row_t             out_params_q;
  logic [ROW_W-1:0] out_row_q;
  logic             out_last_q;
  logic             zz_en_q;

  logic             accept;
  logic             last_acc;
  logic             restart;
  logic             load;
  logic             finish;
  logic             busy;
  logic             wr_en;
  logic [TID_W-1:0] rd_tbl;
  logic [ROW_W-1:0] rd_row;
  row_t             rd_data;
  logic             next_last;
  logic             next_zz;

  // Handshake decode; abort overrides acceptance.
  assign accept   = (state_q == RUN) & out_valid_q & bus.out_ready & ~bus.blk_abort;
  assign last_acc = accept & out_last_q;
  assign restart  = (state_q == IDLE) | last_acc;
  assign load     = (restart & bus.blk_start) | (accept & ~out_last_q);
  assign finish   = (state_q == RUN) & (bus.blk_abort | last_acc);

  // Writes to the table being streamed are refused; bad ids are dropped.
  assign busy  = (state_q == RUN) & (bus.cfg_tbl == act_tbl_q);
  assign wr_en = bus.cfg_we & ~busy & tbl_ok(bus.cfg_tbl);

  // A new block reads row 0 of the requested table, otherwise the next row of the active one.
  assign rd_tbl    = restart ? bus.blk_tbl : act_tbl_q;
  assign rd_row    = restart ? '0 : out_row_q + ROW_W'(1);
  assign next_last = (rd_row == ROW_W'(ROWS - 1));
  assign next_zz   = (32'(rd_row) < ZZ_ROWS);

  quant_tbl_store u_store (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_tbl  (bus.cfg_tbl),
    .wr_row  (bus.cfg_row),
    .wr_data (bus.cfg_data),
    .rd_tbl  (rd_tbl),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // FSM and output registers: load a row on start/advance, drop valid on finish or abort.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      act_tbl_q    <= '0;
      out_valid_q  <= 1'b0;
      out_params_q <= '0;
      out_row_q    <= '0;
      out_last_q   <= 1'b0;
      zz_en_q      <= 1'b0;
    end else if (load) begin
      state_q      <= RUN;
      if (restart) act_tbl_q <= bus.blk_tbl;
      out_valid_q  <= 1'b1;
      out_params_q <= rd_data;
      out_row_q    <= rd_row;
      out_last_q   <= next_last;
      zz_en_q      <= next_zz;
    end else if (finish) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      zz_en_q      <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_params = out_params_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_last   = out_last_q;
  assign bus.zz_en      = zz_en_q;
  assign bus.blk_rdy    = restart;
  assign bus.cfg_busy   = busy;

endmodule

// File: tb/tb_quant_table_seq.sv
// Self-checking bench for quant_table_seq: vector table of blocks, scoreboard on accepted rows, corner sequences.
module tb_quant_table_seq;
  import quant_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  quant_table_seq_if bus ();

  quant_table_seq dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    row_t             params;
    logic [ROW_W-1:0] row;
    logic             last;
    logic             zz;
  } exp_t;

  typedef struct {
    logic [TID_W-1:0] tid;
    bit               toggle;
    bit               chk;
    row_t             row0;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  row_t model [NUM_TBL][ROWS];
  int   tests = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  bit   mon_en = 1'b1;

  row_t             prev_params;
  logic [ROW_W-1:0] prev_row;
  logic             prev_last;
  bit               prev_stall = 1'b0;

  function automatic row_t mk_row(input int c0, input int c1, input int c2, input int c3,
                                  input int c4, input int c5, input int c6, input int c7);
    return {COEF_W'(c7), COEF_W'(c6), COEF_W'(c5), COEF_W'(c4),
            COEF_W'(c3), COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    for (int t = 0; t < int'(NUM_TBL); t++)
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++)
          model[t][r][c*COEF_W +: COEF_W] = (t == 0) ? DEFAULT_LUMA[r][c] : DEFAULT_CHROMA[r][c];
  endtask

  task automatic push_block(input logic [TID_W-1:0] tid);
    exp_t e;
    for (int r = 0; r < int'(ROWS); r++) begin
      e.params = (32'(tid) < NUM_TBL) ? model[tid][r] : '0;
      e.row    = ROW_W'(r);
      e.last   = (r == int'(ROWS) - 1);
      e.zz     = (r < int'(ZZ_ROWS));
      sbq.push_back(e);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"},  64'(bus.out_valid),  64'(0));
    check({tag, "_params"}, 64'(bus.out_params), 64'(0));
    check({tag, "_row"},    64'(bus.out_row),    64'(0));
    check({tag, "_last"},   64'(bus.out_last),   64'(0));
    check({tag, "_zz"},     64'(bus.zz_en),      64'(0));
    check({tag, "_rdy"},    64'(bus.blk_rdy),    64'(1));
    check({tag, "_busy"},   64'(bus.cfg_busy),   64'(0));
  endtask

  task automatic wait_idle();
    int cyc = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check("idle_timeout", 64'(bus.out_valid), 64'(0));
  endtask

  // One full block: latency-1 start, optional 1,0,0,1 ready pattern, exactly ROWS acceptances.
  task automatic run_block(input logic [TID_W-1:0] tid, input bit toggle, input bit chk, input row_t r0);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int base;
    int cyc = 0;
    check("pre_rdy", 64'(bus.blk_rdy), 64'(1));
    push_block(tid);
    bus.blk_tbl   = tid;
    bus.blk_start = 1'b1;
    step();
    bus.blk_start = 1'b0;
    check("lat_valid", 64'(bus.out_valid), 64'(1));
    check("lat_row",   64'(bus.out_row),   64'(0));
    if (chk) check("row0_params", 64'(bus.out_params), 64'(r0));
    base = acc_cnt;
    while (acc_cnt - base < int'(ROWS) && cyc < 200) begin
      bus.out_ready = toggle ? pat[cyc % 4] : 1'b1;
      step();
      cyc++;
    end
    check("end_valid", 64'(bus.out_valid), 64'(0));
    check("end_rdy",   64'(bus.blk_rdy),   64'(1));
    bus.out_ready = 1'b1;
    step();
    step();
    check("rows_accepted", 64'(acc_cnt - base), 64'(ROWS));
    check("sb_empty", 64'(sbq.size()), 64'(0));
  endtask

  // Monitor: hold-stable check on stalls, scoreboard compare on every accepted row.
  always @(negedge clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_params", 64'(bus.out_params), 64'(prev_params));
        check("stall_row",    64'(bus.out_row),    64'(prev_row));
        check("stall_last",   64'(bus.out_last),   64'(prev_last));
      end
      prev_stall  = bus.out_valid && !bus.out_ready && !bus.blk_abort;
      prev_params = bus.out_params;
      prev_row    = bus.out_row;
      prev_last   = bus.out_last;
      if (bus.out_valid && bus.out_ready && !bus.blk_abort) begin
        acc_cnt++;
        if (mon_en) begin
          if (sbq.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL sb_underflow: row %0d accepted, nothing expected", bus.out_row);
          end else begin
            mon_e = sbq.pop_front();
            check("sb_params", 64'(bus.out_params), 64'(mon_e.params));
            check("sb_row",    64'(bus.out_row),    64'(mon_e.row));
            check("sb_last",   64'(bus.out_last),   64'(mon_e.last));
            check("sb_zz",     64'(bus.zz_en),      64'(mon_e.zz));
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs [5];
    row_t luma0;
    row_t chroma0;
    row_t all5;
    row_t all9;
    int   vc;
    int   cyc;

    luma0   = mk_row(64, 86, 73, 73, 57, 43, 21, 14);
    chroma0 = mk_row(60, 57, 43, 22, 11, 11, 11, 11);
    all5    = mk_row(5, 5, 5, 5, 5, 5, 5, 5);
    all9    = mk_row(9, 9, 9, 9, 9, 9, 9, 9);
    vecs[0] = '{tid: 2'd0, toggle: 1'b0, chk: 1'b1, row0: luma0};
    vecs[1] = '{tid: 2'd1, toggle: 1'b1, chk: 1'b1, row0: chroma0};
    vecs[2] = '{tid: 2'd2, toggle: 1'b0, chk: 1'b1, row0: chroma0};
    vecs[3] = '{tid: 2'd3, toggle: 1'b0, chk: 1'b1, row0: '0};
    vecs[4] = '{tid: 2'd0, toggle: 1'b1, chk: 1'b1, row0: luma0};

    bus.cfg_we    = 1'b0;
    bus.cfg_tbl   = '0;
    bus.cfg_row   = '0;
    bus.cfg_data  = '0;
    bus.blk_start = 1'b0;
    bus.blk_tbl   = '0;
    bus.blk_abort = 1'b0;
    bus.out_ready = 1'b1;
    model_defaults();

    nrst = 1'b0;
    step();
    step();
    chk_reset("rst");
    nrst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_block(vecs[i].tid, vecs[i].toggle, vecs[i].chk, vecs[i].row0);

    // Config writes during a block on table 1: other table accepted, active table refused.
    push_block(2'd1);
    bus.out_ready = 1'b1;
    bus.blk_tbl   = 2'd1;
    bus.blk_start = 1'b1;
    step();
    bus.blk_start = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_tbl   = 2'd2;
    bus.cfg_row   = 3'd3;
    bus.cfg_data  = all5;
    #1;
    check("busy_other", 64'(bus.cfg_busy), 64'(0));
    model[2][3] = all5;
    step();
    bus.cfg_tbl = 2'd1;
    #1;
    check("busy_active", 64'(bus.cfg_busy), 64'(1));
    step();
    bus.cfg_we = 1'b0;
    wait_idle();
    check("cfg_sb_empty", 64'(sbq.size()), 64'(0));
    run_block(2'd2, 1'b0, 1'b0, '0);
    run_block(2'd1, 1'b0, 1'b1, chroma0);

    // Back-to-back blocks with blk_start held high.
    push_block(2'd0);
    push_block(2'd0);
    bus.out_ready = 1'b1;
    bus.blk_tbl   = 2'd0;
    bus.blk_start = 1'b1;
    step();
    vc = 0;
    for (int i = 0; i < 2 * int'(ROWS); i++) begin
      if (bus.out_valid) vc++;
      if (i == 2 * int'(ROWS) - 1) bus.blk_start = 1'b0;
      step();
    end
    check("b2b_valid_cycles", 64'(vc), 64'(2 * ROWS));
    check("b2b_end_valid", 64'(bus.out_valid), 64'(0));
    check("b2b_sb_empty", 64'(sbq.size()), 64'(0));

    // Abort at row 4: rows 0..3 delivered, row 4 dropped even though ready is high.
    for (int r = 0; r < 4; r++) begin
      mon_e.params = model[0][r];
      mon_e.row    = ROW_W'(r);
      mon_e.last   = 1'b0;
      mon_e.zz     = (r < int'(ZZ_ROWS));
      sbq.push_back(mon_e);
    end
    bus.blk_tbl   = 2'd0;
    bus.blk_start = 1'b1;
    step();
    bus.blk_start = 1'b0;
    cyc = 0;
    while (bus.out_row != 3'd4 && cyc < 20) begin
      step();
      cyc++;
    end
    check("abort_reach_row4", 64'(bus.out_row), 64'(4));
    check("abort_mid_rdy", 64'(bus.blk_rdy), 64'(0));
    bus.blk_abort = 1'b1;
    step();
    bus.blk_abort = 1'b0;
    check("abort_valid", 64'(bus.out_valid), 64'(0));
    check("abort_last",  64'(bus.out_last),  64'(0));
    check("abort_rdy",   64'(bus.blk_rdy),   64'(1));
    check("abort_sb_empty", 64'(sbq.size()), 64'(0));
    step();

    // Overwrite luma row 0, then reset mid-block and confirm defaults come back.
    bus.cfg_we   = 1'b1;
    bus.cfg_tbl  = 2'd0;
    bus.cfg_row  = 3'd0;
    bus.cfg_data = all9;
    step();
    bus.cfg_we  = 1'b0;
    model[0][0] = all9;
    run_block(2'd0, 1'b0, 1'b1, all9);
    mon_en        = 1'b0;
    bus.blk_tbl   = 2'd0;
    bus.blk_start = 1'b1;
    step();
    bus.blk_start = 1'b0;
    step();
    step();
    nrst = 1'b0;
    step();
    chk_reset("midrst");
    nrst = 1'b1;
    sbq.delete();
    model_defaults();
    step();
    mon_en = 1'b1;
    run_block(2'd0, 1'b0, 1'b1, luma0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
